// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: default widths,
// arbiter state encoding and master index constants.
package mem_arbiter_pkg;

    localparam int unsigned DEF_WORD_SIZE = 16;
    localparam int unsigned DEF_ADDR_SIZE = 16;
    localparam int unsigned DEF_BURST_MAX = 8;

    // Master indices (CPU = 0, DMA/loader = 1)
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // Ownership state for a master index
    function automatic arb_state_e own_state(input logic idx);
        return idx ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick between two requesters.
// Ports:
//   req[1:0]     - request per master
//   last_served  - index of the master served most recently
//   owner_c      - chosen master index (meaningful when valid_c = 1)
//   valid_c      - at least one master requests
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       owner_c,
    output logic       valid_c
);

    // A lone requester wins; on contention the master not served last wins
    always_comb begin
        owner_c = M0_IDX;
        valid_c = |req;
        case (req)
            2'b01:   owner_c = M0_IDX;
            2'b10:   owner_c = M1_IDX;
            2'b11:   owner_c = ~last_served;
            default: owner_c = M0_IDX;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between master 0 (CPU) and master 1
// (DMA/loader) with round-robin arbitration and capped locked bursts.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   mK_req/lock/write/addr/wdata - master K request (held until mK_gnt)
//   mK_gnt                     - beat accepted this cycle (from registered state)
//   mK_rvalid, mK_rdata        - read return, one cycle after a granted read
//   memory_addr/out/write      - memory bus, driven by the granted master
//   memory_in                  - memory read data, one cycle after the address
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX   // legal range 2..255
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_req,
    input  logic                 m0_lock,
    input  logic                 m0_write,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [WORD_SIZE-1:0] m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_lock,
    input  logic                 m1_write,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [WORD_SIZE-1:0] m1_rdata,

    output logic [ADDR_SIZE-1:0] memory_addr,
    output logic [WORD_SIZE-1:0] memory_out,
    output logic                 memory_write,
    input  logic [WORD_SIZE-1:0] memory_in
);

    localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_served_q, last_served_d;
    logic             m0_rvalid_q, m0_rvalid_d;
    logic             m1_rvalid_q, m1_rvalid_d;

    logic             own_idx;
    logic             own_req;
    logic             own_lock;
    logic             pick_last;
    logic             pick_owner;
    logic             pick_valid;
    logic             last_beat;

    // Current owner's view of its request lines
    assign own_idx  = (state_q == ARB_OWN1);
    assign own_req  = own_idx ? m1_req  : m0_req;
    assign own_lock = own_idx ? m1_lock : m0_lock;
    assign last_beat = (beat_cnt_q == CNT_W'(BURST_MAX - 1));

    // While owning, the owner counts as last served so a waiting master wins
    // the hand-over; in IDLE the stored history decides.
    assign pick_last = (state_q == ARB_IDLE) ? last_served_q : own_idx;

    arb_rr_pick u_pick (
        .req         ({m1_req, m0_req}),
        .last_served (pick_last),
        .owner_c     (pick_owner),
        .valid_c     (pick_valid)
    );

    // Grants and memory bus follow the registered owner
    assign m0_gnt = (state_q == ARB_OWN0) && m0_req;
    assign m1_gnt = (state_q == ARB_OWN1) && m1_req;

    assign memory_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
    assign memory_out   = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);
    assign memory_write = (m0_gnt && m0_write) || (m1_gnt && m1_write);

    // Read return: registered valid, data passed through from memory
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rvalid_q ? memory_in : '0;
    assign m1_rdata  = m1_rvalid_q ? memory_in : '0;

    // Next-state: ownership, burst count and round-robin history
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_served_d = last_served_q;
        m0_rvalid_d   = m0_gnt && !m0_write;
        m1_rvalid_d   = m1_gnt && !m1_write;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = own_state(pick_owner);
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (own_req) begin
                    if (!own_lock || last_beat) begin
                        // Tenure ends; pick includes the owner itself, so a
                        // lone owner simply starts a new tenure.
                        beat_cnt_d    = '0;
                        last_served_d = own_idx;
                        state_d       = own_state(pick_owner);
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    beat_cnt_d = '0;
                    state_d    = pick_valid ? own_state(pick_owner) : ARB_IDLE;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            beat_cnt_q    <= '0;
            last_served_q <= M1_IDX;
            m0_rvalid_q   <= 1'b0;
            m1_rvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_served_q <= last_served_d;
            m0_rvalid_q   <= m0_rvalid_d;
            m1_rvalid_q   <= m1_rvalid_d;
        end
    end

endmodule
